// File: rtl/accumulate_stage_16bit_if.sv
// ----------------------------------------------------------------------------
// accumulate_stage_16bit_if
//   Bundles the operand stream, the result stream and the loop to the
//   external ripple-carry adder for accumulate_stage_16bit.
//
//   Signals (direction seen from the accumulator, i.e. the slave modport):
//     in_valid / in_ready / in_data / frame_len   operand stream (in / out / in / in)
//     add_a / add_b / add_cin                     adder operands (out)
//     add_sum / add_cout                          adder combinational return (in)
//     out_valid / out_ready                       result stream handshake (out / in)
//     out_sum / out_carries                       frame result (out)
//
//   Modports:
//     slave  - the accumulator
//     master - the environment (operand source, result sink, adder)
// ----------------------------------------------------------------------------
interface accumulate_stage_16bit_if #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [COUNT_W-1:0] frame_len;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_sum;
  logic [COUNT_W-1:0] out_carries;

  modport slave (
    input  in_valid, in_data, frame_len, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_carries
  );

  modport master (
    output in_valid, in_data, frame_len, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_carries
  );
endinterface

// File: rtl/accumulate_stage_16bit.sv
// ----------------------------------------------------------------------------
// accumulate_stage_16bit
//   Frame accumulator sitting downstream of a 16-bit ripple-carry adder.
//   The accumulator register feeds adder operand A, the incoming operand
//   feeds operand B, and the adder's sum/carry-out are registered on every
//   accepted operand. After frame_len operands (0 treated as 1) the frame
//   sum and the number of carry-out events are presented on the result
//   stream and held until out_ready.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset; discards any partial frame
//     bus    accumulate_stage_16bit_if.slave (operand stream, adder loop,
//            result stream)
//
//   Build option:
//     ACC_SATURATE_EN  when defined, any carry-out during a frame pins the
//                      accumulator to all-ones for the rest of the frame
//                      (carry-outs are still counted). When undefined the
//                      sum wraps modulo 2^WIDTH.
// ----------------------------------------------------------------------------
module accumulate_stage_16bit #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  accumulate_stage_16bit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   acc;
  logic [COUNT_W-1:0] carries;
  logic [COUNT_W-1:0] remaining;
  logic               accept;
  logic               in_ready;
  logic               out_valid;

`ifdef ACC_SATURATE_EN
  logic               sat_flag;

  // Once a carry-out has been seen in this frame the accumulator is pinned
  // to all-ones; the flag keeps it there even if a later add would not carry.
  function automatic logic [WIDTH-1:0] sat_acc(input logic [WIDTH-1:0] sum,
                                               input logic             cout,
                                               input logic             flag);
    return (cout || flag) ? {WIDTH{1'b1}} : sum;
  endfunction
`endif

  // Operands still expected after the first one; a zero length is a
  // one-operand frame.
  function automatic logic [COUNT_W-1:0] first_remaining(input logic [COUNT_W-1:0] len);
    return (len == '0) ? '0 : len - COUNT_W'(1);
  endfunction

  // Control: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control: next state and handshakes
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        accept   = bus.in_valid && rst_n;
        if (accept) begin
          state_nxt = (first_remaining(bus.frame_len) == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = rst_n;
        accept   = bus.in_valid && rst_n;
        if (accept && (remaining == COUNT_W'(1))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: accumulator, carry count and remaining-operand counter.
  // These are reset as well because IDLE relies on acc=0 so that the first
  // operand passes through the adder unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      carries   <= '0;
      remaining <= '0;
`ifdef ACC_SATURATE_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc       <= bus.add_sum;
            remaining <= first_remaining(bus.frame_len);
          end
        end
        ACCUM: begin
          if (accept) begin
`ifdef ACC_SATURATE_EN
            acc      <= sat_acc(bus.add_sum, bus.add_cout, sat_flag);
            sat_flag <= sat_flag | bus.add_cout;
`else
            acc      <= bus.add_sum;
`endif
            carries   <= carries + COUNT_W'(bus.add_cout);
            remaining <= remaining - COUNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            acc      <= '0;
            carries  <= '0;
`ifdef ACC_SATURATE_EN
            sat_flag <= 1'b0;
`endif
          end
        end
        default: begin
          acc     <= '0;
          carries <= '0;
        end
      endcase
    end
  end

  // Outputs: adder loop and result stream. Results read as zero outside DONE.
  assign bus.add_a       = acc;
  assign bus.add_b       = bus.in_data;
  assign bus.add_cin     = 1'b0;
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_sum     = out_valid ? acc : '0;
  assign bus.out_carries = out_valid ? carries : '0;

endmodule

// File: tb/tb_accumulate_stage_16bit.sv
module tb_accumulate_stage_16bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  accumulate_stage_16bit_if #(.WIDTH(16), .COUNT_W(8)) bus();

  accumulate_stage_16bit #(.WIDTH(16), .COUNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External ripple-carry adder behaviour
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'b0, bus.add_cin};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] sum;
    logic [7:0]  car;
    int          due;
  } exp_t;
  exp_t expq[$];

  logic [15:0] ops [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard: result must appear exactly on its due cycle and stay until taken
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
    end else if (expq.size() > 0 && cyc >= expq[0].due) begin
      chk("sb_out_valid", bus.out_valid, 1);
      chk("sb_out_sum", bus.out_sum, expq[0].sum);
      chk("sb_out_carries", bus.out_carries, expq[0].car);
      if (bus.out_ready) void'(expq.pop_front());
    end else begin
      chk("sb_out_valid_low", bus.out_valid, 0);
    end
  end

  // Offer one operand, wait (bounded) for acceptance
  task automatic send_op(input logic [15:0] d, input logic [7:0] fl, output int acc_cyc);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.frame_len = fl;
    acc_cyc = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept data=%0h", d);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Send ops[0..n-1] as one frame; model computes the expected result
  task automatic send_frame(input int n, input logic [7:0] fl, input logic [7:0] fl_later,
                            input int gap, output int first_cyc);
    logic [16:0] t;
    logic [15:0] a;
    logic [7:0]  c;
    logic        sat;
    int          ac;
    exp_t        e;
    a = 16'h0; c = 8'h0; sat = 1'b0; first_cyc = -1; ac = -1;
    for (int i = 0; i < n; i++) begin
      send_op(ops[i], (i == 0) ? fl : fl_later, ac);
      if (i == 0) begin
        first_cyc = ac;
        a = ops[0];
      end else begin
        t = {1'b0, a} + {1'b0, ops[i]};
        if (t[16]) c = c + 8'd1;
`ifdef ACC_SATURATE_EN
        if (t[16]) sat = 1'b1;
        a = sat ? 16'hFFFF : t[15:0];
`else
        a = t[15:0];
`endif
      end
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("gap_in_ready", bus.in_ready, 1);
          chk("gap_acc_hold", bus.add_a, a);
          @(posedge clk); #1;
        end
      end
    end
    e.sum = a; e.car = c; e.due = ac + 1;
    expq.push_back(e);
  endtask

  // Hand-computed expectation on the cycle right after the last accept
  task automatic check_lit(input string name, input logic [15:0] s, input logic [7:0] c);
    @(negedge clk);
    chk({name, "_valid"}, bus.out_valid, 1);
    chk({name, "_sum"}, bus.out_sum, s);
    chk({name, "_carries"}, bus.out_carries, c);
    @(posedge clk); #1;
  endtask

  initial begin
    int fc;
    int ac;
    int rel;
    bus.in_valid = 1'b0; bus.in_data = 16'h0; bus.frame_len = 8'h0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_out_carries", bus.out_carries, 0);
    chk("rst_add_a", bus.add_a, 0);
    chk("rst_add_cin", bus.add_cin, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame
    ops[0] = 16'h0001; ops[1] = 16'h0002; ops[2] = 16'h0003;
    send_frame(3, 8'd3, 8'd3, 0, fc);
    check_lit("basic", 16'h0006, 8'd0);

    // Carry handling
    ops[0] = 16'hFFFF; ops[1] = 16'h0002;
    send_frame(2, 8'd2, 8'd2, 0, fc);
`ifdef ACC_SATURATE_EN
    check_lit("carry", 16'hFFFF, 8'd1);
`else
    check_lit("carry", 16'h0001, 8'd1);
`endif

    // Zero-length frame
    ops[0] = 16'h1234;
    send_frame(1, 8'd0, 8'd0, 0, fc);
    check_lit("zero_len", 16'h1234, 8'd0);

    // Multiple carries; frame_len changes after the first operand are ignored
    ops[0] = 16'h8000; ops[1] = 16'h8000; ops[2] = 16'h8000; ops[3] = 16'h8000; ops[4] = 16'h0001;
    send_frame(5, 8'd5, 8'd1, 0, fc);
`ifdef ACC_SATURATE_EN
    check_lit("multi_carry", 16'hFFFF, 8'd4);
`else
    check_lit("multi_carry", 16'h0001, 8'd2);
`endif

    // Output backpressure
    bus.out_ready = 1'b0;
    ops[0] = 16'h0100; ops[1] = 16'h0023;
    send_frame(2, 8'd2, 8'd2, 0, fc);
    bus.in_valid = 1'b1; bus.in_data = 16'h5555; bus.frame_len = 8'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_sum", bus.out_sum, 16'h0123);
      chk("bp_out_carries", bus.out_carries, 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    rel = cyc;
    ops[0] = 16'h5555;
    send_frame(1, 8'd1, 8'd1, 0, fc);
    chk("bp_first_accept_cycle", fc, rel + 1);
    check_lit("bp_next", 16'h5555, 8'd0);

    // Reset mid-frame
    send_op(16'h0011, 8'd4, ac);
    send_op(16'h0022, 8'd4, ac);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_sum", bus.out_sum, 0);
    chk("midrst_out_carries", bus.out_carries, 0);
    chk("midrst_add_a", bus.add_a, 0);
    @(posedge clk); #1;
    ops[0] = 16'h0005; ops[1] = 16'h0005;
    send_frame(2, 8'd2, 8'd2, 0, fc);
    check_lit("after_rst", 16'h000A, 8'd0);

    // Input bubbles
    ops[0] = 16'h1000; ops[1] = 16'h1000; ops[2] = 16'h1000;
    send_frame(3, 8'd3, 8'd3, 2, fc);
    check_lit("bubbles", 16'h3000, 8'd0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
